// File: rtl/vga_sched_pkg.sv
// Shared 640x480@60 raster constants and scheduler FSM state type
// for the VGA update scheduler.
package vga_sched_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FRONT  = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BACK   = 48;
  localparam int VGA_H_LINE   = VGA_H_ACTIVE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FRONT  = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BACK   = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  // Line counter starts at sync, so active video begins after sync + back porch.
  localparam int VGA_V_ACTIVE_START = VGA_V_SYNC + VGA_V_BACK;
  localparam int VGA_V_BLANK_START  = VGA_V_ACTIVE_START + VGA_V_ACTIVE;

  localparam int DEFAULT_MAX_SLOT = 1024;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARB,
    S_BUSY
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first eligible bit strictly after last_idx_i,
// wrapping cyclically; returns one-hot grant, its index and a valid flag.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  elig_i,
  input  logic [IW-1:0] last_idx_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  logic [IW-1:0] pos;
  int            p;

  // Walk offsets from farthest to nearest so the nearest eligible bit is the
  // last one written and therefore wins.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    p       = 0;
    pos     = '0;
    for (int off = N; off >= 1; off--) begin
      p   = (int'(last_idx_i) + off) % N;
      pos = IW'(p);
      if (elig_i[pos]) begin
        gnt_o      = '0;
        gnt_o[pos] = 1'b1;
        idx_o      = pos;
        valid_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_update_scheduler.sv
// Opens one game-state update window per frame during vertical blanking and
// grants requesters round-robin. Optional grant timeout: SCHED_TIMEOUT_EN.
module vga_update_scheduler
  import vga_sched_pkg::*;
#(
  parameter int N_REQ          = 3,
  parameter int H_LINE         = VGA_H_LINE,
  parameter int V_ACTIVE_START = VGA_V_ACTIVE_START,
  parameter int V_BLANK_START  = VGA_V_BLANK_START
`ifdef SCHED_TIMEOUT_EN
  , parameter int MAX_SLOT     = DEFAULT_MAX_SLOT
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [11:0]      h_cnt,
  input  logic [11:0]      v_cnt,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] grant,
  output logic             vblank,
  output logic             frame_tick,
  output logic             overrun,
  output logic [15:0]      frame_cnt
);

  localparam int IW = $clog2(N_REQ);

  sched_state_e     state_q, state_d;
  logic             armed_q, armed_d;
  logic             vblank_q, vblank_d;
  logic             frame_tick_q, frame_tick_d;
  logic             overrun_q, overrun_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] served_q, served_d;
  logic [IW-1:0]    last_q, last_d;
  logic [IW-1:0]    gidx_q, gidx_d;

  logic             in_window;
  logic             done_hit;
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] arb_gnt;
  logic [IW-1:0]    arb_idx;
  logic             arb_valid;

`ifdef SCHED_TIMEOUT_EN
  localparam int SW = $clog2(MAX_SLOT) + 1;
  logic [SW-1:0] slot_q, slot_d;
  logic          slot_expired;
  assign slot_expired = (slot_q == SW'(MAX_SLOT - 1));
`endif

  assign in_window = (v_cnt >= 12'(V_BLANK_START)) || (v_cnt < 12'(V_ACTIVE_START));
  assign done_hit  = |(done & grant_q);
  assign elig      = req & ~served_q;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr (
    .elig_i     (elig),
    .last_idx_i (last_q),
    .gnt_o      (arb_gnt),
    .idx_o      (arb_idx),
    .valid_o    (arb_valid)
  );

  // A window only counts once an active line has been seen since reset, so
  // leaving reset inside blanking waits for the next real frame.
  always_comb begin
    armed_d      = armed_q | ~in_window;
    vblank_d     = in_window & armed_q;
    frame_tick_d = vblank_d & ~vblank_q;
    frame_cnt_d  = frame_tick_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
  end

  // Frame-start clears come first so that a same-cycle set below overrides.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    served_d  = frame_tick_d ? '0 : served_q;
    overrun_d = frame_tick_d ? 1'b0 : overrun_q;
    last_d    = last_q;
    gidx_d    = gidx_q;
`ifdef SCHED_TIMEOUT_EN
    slot_d    = (state_q == S_BUSY) ? slot_q + 1'b1 : '0;
`endif
    case (state_q)
      S_IDLE: begin
        grant_d = '0;
        if (frame_tick_q) state_d = S_ARB;
      end
      S_ARB: begin
        if (!vblank_d) begin
          state_d = S_IDLE;
        end else if (arb_valid) begin
          grant_d = arb_gnt;
          gidx_d  = arb_idx;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (done_hit) begin
          grant_d  = '0;
          served_d = served_d | grant_q;
          last_d   = gidx_q;
          state_d  = S_ARB;
        end else if (!vblank_d) begin
          grant_d   = '0;
          served_d  = served_d | grant_q;
          overrun_d = 1'b1;
          state_d   = S_IDLE;
        end
`ifdef SCHED_TIMEOUT_EN
        else if (slot_expired) begin
          grant_d   = '0;
          served_d  = served_d | grant_q;
          overrun_d = 1'b1;
          state_d   = S_ARB;
        end
`endif
      end
      default: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      armed_q      <= 1'b0;
      vblank_q     <= 1'b0;
      frame_tick_q <= 1'b0;
      overrun_q    <= 1'b0;
      frame_cnt_q  <= '0;
      grant_q      <= '0;
      served_q     <= '0;
      last_q       <= IW'(N_REQ - 1);
      gidx_q       <= '0;
`ifdef SCHED_TIMEOUT_EN
      slot_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      vblank_q     <= vblank_d;
      frame_tick_q <= frame_tick_d;
      overrun_q    <= overrun_d;
      frame_cnt_q  <= frame_cnt_d;
      grant_q      <= grant_d;
      served_q     <= served_d;
      last_q       <= last_d;
      gidx_q       <= gidx_d;
`ifdef SCHED_TIMEOUT_EN
      slot_q       <= slot_d;
`endif
    end
  end

  // The horizontal counter is not needed for scheduling; only its range is checked.
  a_h_cnt_range : assert property (@(posedge clk) disable iff (rst) h_cnt < 12'(H_LINE));

  assign grant      = grant_q;
  assign vblank     = vblank_q;
  assign frame_tick = frame_tick_q;
  assign overrun    = overrun_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_vga_update_scheduler.sv
// Directed bench for vga_update_scheduler: a reset/first-frame vector table
// followed by hand-written multi-cycle sequences.
module tb_vga_update_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] h_cnt;
  logic [11:0] v_cnt;
  logic [2:0]  req;
  logic [2:0]  done;
  logic [2:0]  grant;
  logic        vblank;
  logic        frame_tick;
  logic        overrun;
  logic [15:0] frame_cnt;

  int n_vec = 0;
  int n_err = 0;
  int exp_fc = 0;

  always #5 clk = ~clk;

  vga_update_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .req        (req),
    .done       (done),
    .grant      (grant),
    .vblank     (vblank),
    .frame_tick (frame_tick),
    .overrun    (overrun),
    .frame_cnt  (frame_cnt)
  );

  typedef struct {
    logic        rst;
    logic [11:0] v;
    logic [2:0]  req;
    logic [2:0]  done;
    logic [2:0]  g;
    logic        vb;
    logic        tk;
    logic        ov;
    logic [15:0] fc;
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Opens a window, checks the tick cycle, and steps to the first grant cycle.
  task automatic open_frame();
    v_cnt = 12'd515;
    step();
    exp_fc++;
    chk("tick", 32'(frame_tick), 32'd1);
    chk("tick_vblank", 32'(vblank), 32'd1);
    chk("tick_fcnt", 32'(frame_cnt), 32'(exp_fc));
    chk("tick_overrun", 32'(overrun), 32'd0);
    step();
    step();
  endtask

  task automatic close_frame();
    v_cnt = 12'd100;
    step();
    chk("close_vblank", 32'(vblank), 32'd0);
  endtask

  // Grant exp is assumed valid now; hold it for 'hold' cycles, then pulse done.
  task automatic serve(input logic [2:0] exp, input int hold);
    chk("grant", 32'(grant), 32'(exp));
    repeat (hold - 1) step();
    chk("grant_held", 32'(grant), 32'(exp));
    done = exp;
    step();
    done = 3'b000;
    chk("release", 32'(grant), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst   = 1'b1;
    h_cnt = 12'd0;
    v_cnt = 12'd0;
    req   = 3'b000;
    done  = 3'b000;

    //           rst   v        req     done    g       vb    tk    ov    fc
    vecs[0] = '{1'b1, 12'd0,   3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[1] = '{1'b0, 12'd0,   3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[2] = '{1'b0, 12'd100, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[3] = '{1'b0, 12'd514, 3'b111, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[4] = '{1'b0, 12'd515, 3'b111, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0, 16'd1};
    vecs[5] = '{1'b0, 12'd515, 3'b111, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 16'd1};
    vecs[6] = '{1'b0, 12'd515, 3'b111, 3'b000, 3'b001, 1'b1, 1'b0, 1'b0, 16'd1};

    step();
    for (int i = 0; i < 7; i++) begin
      rst   = vecs[i].rst;
      v_cnt = vecs[i].v;
      req   = vecs[i].req;
      done  = vecs[i].done;
      step();
      chk($sformatf("v%0d_grant", i), 32'(grant), 32'(vecs[i].g));
      chk($sformatf("v%0d_vblank", i), 32'(vblank), 32'(vecs[i].vb));
      chk($sformatf("v%0d_tick", i), 32'(frame_tick), 32'(vecs[i].tk));
      chk($sformatf("v%0d_overrun", i), 32'(overrun), 32'(vecs[i].ov));
      chk($sformatf("v%0d_fcnt", i), 32'(frame_cnt), 32'(vecs[i].fc));
    end
    exp_fc = 1;

    // req=111, done 10 cycles after each grant: 001, 010, 100, no repeats
    serve(3'b001, 10);
    step();
    serve(3'b010, 10);
    step();
    serve(3'b100, 10);
    repeat (20) step();
    chk("no_regrant", 32'(grant), 32'd0);
    chk("still_open", 32'(vblank), 32'd1);
    close_frame();
    chk("clean_close_overrun", 32'(overrun), 32'd0);

    // req=101 over two frames: pointer skips idle bit 1 and wraps to 0
    req = 3'b101;
    for (int f = 0; f < 2; f++) begin
      open_frame();
      serve(3'b001, 1);
      step();
      serve(3'b100, 1);
      close_frame();
    end

    // Silent holder until the window closes: overrun, then cleared at next tick
    req = 3'b001;
    open_frame();
    chk("silent_grant", 32'(grant), 32'd1);
    repeat (30) step();
    chk("silent_held", 32'(grant), 32'd1);
    v_cnt = 12'd35;
    step();
    chk("close_grant", 32'(grant), 32'd0);
    chk("close_overrun", 32'(overrun), 32'd1);
    chk("close_vblank", 32'(vblank), 32'd0);
    open_frame();
    chk("grant_after_ovr", 32'(grant), 32'd1);
    repeat (4) step();
    v_cnt = 12'd35;
    done  = 3'b001;
    step();
    done = 3'b000;
    chk("done_close_grant", 32'(grant), 32'd0);
    chk("done_close_overrun", 32'(overrun), 32'd0);
    step();

`ifdef SCHED_TIMEOUT_EN
    // Silent holder with timeout: drop after 1024 cycles, next granted right after
    req = 3'b011;
    open_frame();
    chk("to_grant", 32'(grant), 32'd2);
    repeat (1023) step();
    chk("to_held", 32'(grant), 32'd2);
    step();
    chk("to_drop", 32'(grant), 32'd0);
    chk("to_overrun", 32'(overrun), 32'd1);
    step();
    serve(3'b001, 1);
    close_frame();
    open_frame();
    serve(3'b010, 1);
    close_frame();
`endif

    // Reset while requester 1 holds the grant
    req = 3'b010;
    open_frame();
    chk("pre_rst_grant", 32'(grant), 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_fcnt", 32'(frame_cnt), 32'd0);
    chk("rst_vblank", 32'(vblank), 32'd0);
    repeat (3) step();
    chk("unarmed_vblank", 32'(vblank), 32'd0);
    chk("unarmed_tick", 32'(frame_tick), 32'd0);
    req = 3'b111;
    close_frame();
    exp_fc = 0;
    open_frame();
    chk("post_rst_first", 32'(grant), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
